// File: rtl/rv6_dcache_pkg.sv
// Shared definitions for the rv6 set-associative data cache: access-length codes,
// controller state encoding and the access-size helper.
package rv6_dcache_pkg;

  localparam logic [2:0] LEN_B   = 3'd0;
  localparam logic [2:0] LEN_H   = 3'd1;
  localparam logic [2:0] LEN_W   = 3'd2;
  localparam logic [2:0] LEN_D   = 3'd3;
  localparam logic [2:0] LEN_BU  = 3'd4;
  localparam logic [2:0] LEN_HU  = 3'd5;
  localparam logic [2:0] LEN_WU  = 3'd6;
  localparam logic [2:0] LEN_RSV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } dcache_state_e;

  // Reserved length reports 8 bytes here; it is flagged misaligned by the caller.
  function automatic logic [3:0] access_bytes(input logic [2:0] len);
    case (len)
      LEN_B, LEN_BU: return 4'd1;
      LEN_H, LEN_HU: return 4'd2;
      LEN_W, LEN_WU: return 4'd4;
      default:       return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dcache_plru.sv
// Per-set tree pseudo-LRU, WAYS-1 bits per set. Level l of the tree splits on way
// bit l (LSB at the root); each node bit points toward the half to evict next.
module dcache_plru #(
  parameter int SETS = 4,
  parameter int WAYS = 4,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [SET_W-1:0] set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             touch_en,
  output logic [WAY_W-1:0] victim_way
);

  logic [WAYS-2:0]  tree_q [SETS];
  logic [WAYS-2:0]  tree_d;
  logic [WAY_W-1:0] t_node;
  logic [WAY_W-1:0] v_node;

  always_comb begin
    tree_d = tree_q[set];
    t_node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      tree_d[t_node] = ~touch_way[l];
      if (l < WAY_W - 1) t_node = WAY_W'(2 * t_node + 1 + touch_way[l]);
    end
  end

  always_comb begin
    victim_way = '0;
    v_node     = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way[l] = tree_q[set][v_node];
      if (l < WAY_W - 1) v_node = WAY_W'(2 * v_node + 1 + victim_way[l]);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (touch_en) begin
      tree_q[set] <= tree_d;
    end
  end

endmodule

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-allocate, write-through L1 data cache with tree-PLRU.
// Define DCACHE_PERF_EN to add the hit_cnt/miss_cnt performance counters.
module dcache_sa
  import rv6_dcache_pkg::*;
#(
  parameter int SETS       = 4,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 128,
  parameter int ADDR_W     = 64,
  localparam int LW        = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        len,
  input  logic              rd,
  input  logic              wr,
  input  logic [63:0]       data_in,
  output logic [63:0]       data_out,
  output logic              ready,
  output logic              misalign,
  output logic [ADDR_W-1:0] b_addr,
  output logic              b_rd,
  input  logic [LW-1:0]     b_data_in,
  input  logic              b_dv,
  output logic              b_wr,
  output logic [LW-1:0]     b_data_out,
  input  logic              b_wa,
`ifdef DCACHE_PERF_EN
  output logic [63:0]       hit_cnt,
  output logic [63:0]       miss_cnt,
`endif
  output dcache_state_e     dbg_state
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - SET_W;

  // Handshake: the requester holds addr/len/rd/wr/data_in stable while rd|wr is high;
  // the access is complete in the cycle ready=1 and a new one may be presented after it.
  dcache_state_e    state_q;
  logic [LW-1:0]    line_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];

  logic [OFF_W-1:0] off;
  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag;
  logic [3:0]       size_mask;
  logic             req, is_store, misaligned;
  logic             hit, has_inv;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, fill_way, we_way;
  logic [LW-1:0]    hit_line, new_line;
  logic [63:0]      raw;
  logic             load_hit, store_hit, miss, fill, line_we;

  assign off        = addr[OFF_W-1:0];
  assign set_idx    = addr[OFF_W +: SET_W];
  assign tag        = addr[ADDR_W-1 -: TAG_W];
  assign req        = rd | wr;
  assign is_store   = wr;
  assign size_mask  = access_bytes(len) - 4'd1;
  assign misaligned = (len == LEN_RSV) || ((addr[3:0] & size_mask) != 4'd0);
  assign b_addr     = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dbg_state  = state_q;

  function automatic logic [LW-1:0] merge_store(input logic [LW-1:0] line,
                                                input logic [OFF_W-1:0] boff,
                                                input logic [2:0] blen,
                                                input logic [63:0] data);
    logic [LW-1:0]    m;
    logic [OFF_W+2:0] bidx;
    m = line;
    for (int i = 0; i < 8; i++) begin
      bidx = {boff + OFF_W'(i), 3'b000};
      if (4'(i) < access_bytes(blen)) m[bidx +: 8] = data[i*8 +: 8];
    end
    return m;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign fill_way  = has_inv ? inv_way : plru_way;
  assign hit_line  = line_q[set_idx][hit_way];
  assign raw       = 64'(hit_line >> {off, 3'b000});

  assign load_hit  = (state_q == ST_IDLE) && req && !misaligned && !is_store && hit;
  assign store_hit = (state_q == ST_IDLE) && req && !misaligned && is_store && hit;
  assign miss      = (state_q == ST_IDLE) && req && !misaligned && !hit;
  assign fill      = (state_q == ST_REFILL) && b_dv;
  assign line_we   = fill || store_hit;
  assign we_way    = fill ? fill_way : hit_way;
  assign new_line  = fill ? (is_store ? merge_store(b_data_in, off, len, data_in) : b_data_in)
                          : merge_store(hit_line, off, len, data_in);

  assign misalign  = req && misaligned;
  assign ready     = misalign || load_hit || ((state_q == ST_WRITE) && b_wa);

  always_comb begin
    case (len)
      LEN_B:   data_out = {{56{raw[7]}},  raw[7:0]};
      LEN_H:   data_out = {{48{raw[15]}}, raw[15:0]};
      LEN_W:   data_out = {{32{raw[31]}}, raw[31:0]};
      LEN_BU:  data_out = {56'd0, raw[7:0]};
      LEN_HU:  data_out = {48'd0, raw[15:0]};
      LEN_WU:  data_out = {32'd0, raw[31:0]};
      default: data_out = raw;
    endcase
    if (!hit) data_out = '0;
  end

  dcache_plru #(.SETS(SETS), .WAYS(WAYS)) u_plru (
    .clk        (clk),
    .clr_n      (clr_n),
    .set        (set_idx),
    .touch_way  (we_way),
    .touch_en   (load_hit || line_we),
    .victim_way (plru_way)
  );

  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[set_idx][we_way] <= new_line;
      tag_q[set_idx][we_way]  <= tag;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      b_rd       <= 1'b0;
      b_wr       <= 1'b0;
      b_data_out <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            b_rd    <= 1'b1;
            state_q <= ST_REFILL;
          end else if (store_hit) begin
            b_data_out <= new_line;
            b_wr       <= 1'b1;
            state_q    <= ST_WRITE;
          end
        end
        ST_REFILL: begin
          if (b_dv) begin
            b_rd                      <= 1'b0;
            valid_q[set_idx][fill_way] <= 1'b1;
            if (is_store) begin
              b_data_out <= new_line;
              b_wr       <= 1'b1;
              state_q    <= ST_WRITE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (b_wa) begin
            b_wr    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  // A miss stays pending through refill so the post-fill hit cycle still counts as a miss.
  logic pend_miss_q;
  logic done;
  assign done = load_hit || ((state_q == ST_WRITE) && b_wa);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      pend_miss_q <= 1'b0;
    end else begin
      if (miss) pend_miss_q <= 1'b1;
      if (done) begin
        pend_miss_q <= 1'b0;
        if (pend_miss_q) miss_cnt <= miss_cnt + 64'd1;
        else             hit_cnt  <= hit_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Bench for dcache_sa: directed scenarios plus random traffic checked against a
// byte-addressed memory image and a history-based model of the cache contents.
module tb_dcache_sa;
  import rv6_dcache_pkg::*;

  localparam int SETS       = 4;
  localparam int WAYS       = 4;
  localparam int WAY_LOG    = 2;
  localparam int LINE_BYTES = 128;
  localparam int ADDR_W     = 64;
  localparam int LW         = 8 * LINE_BYTES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]   addr = '0;
  logic [2:0]    len = '0;
  logic          rd = 1'b0, wr = 1'b0;
  logic [63:0]   data_in = '0;
  logic [63:0]   data_out;
  logic          ready, misalign;
  logic [63:0]   b_addr;
  logic          b_rd, b_wr;
  logic [LW-1:0] b_data_in = '0;
  logic          b_dv = 1'b0, b_wa = 1'b0;
  logic [LW-1:0] b_data_out;
  dcache_state_e dbg_state;
`ifdef DCACHE_PERF_EN
  logic [63:0]   hit_cnt, miss_cnt;
`endif

  dcache_sa #(.SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .addr       (addr),
    .len        (len),
    .rd         (rd),
    .wr         (wr),
    .data_in    (data_in),
    .data_out   (data_out),
    .ready      (ready),
    .misalign   (misalign),
    .b_addr     (b_addr),
    .b_rd       (b_rd),
    .b_data_in  (b_data_in),
    .b_dv       (b_dv),
    .b_wr       (b_wr),
    .b_data_out (b_data_out),
    .b_wa       (b_wa),
`ifdef DCACHE_PERF_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0]      mem [longint unsigned];
  bit              m_valid [SETS][WAYS];
  longint unsigned m_line  [SETS][WAYS];
  longint unsigned m_last  [SETS][WAYS];
  longint unsigned tick = 0;
  logic [63:0]     tags [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [63:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < LINE_BYTES; i++) l[i*8 +: 8] = mem_byte(base + 64'(i));
    return l;
  endfunction

  function automatic int size_of(input logic [2:0] l);
    return 1 << int'(l & 3'd3);
  endfunction

  function automatic logic [63:0] load_value(input logic [63:0] a, input logic [2:0] l);
    int sz;
    logic [63:0] v;
    sz = size_of(l);
    v = '0;
    for (int i = 0; i < sz; i++) v[i*8 +: 8] = mem_byte(a + 64'(i));
    if (l < 3'd3 && v[8*sz-1]) for (int i = sz; i < 8; i++) v[i*8 +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_last[s][w]  = 0;
      end
  endfunction

  function automatic bit model_lookup(input logic [63:0] a, output int way);
    int s;
    s = int'((a / LINE_BYTES) % SETS);
    way = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == a / LINE_BYTES) begin
        way = w;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void model_touch(input int s, input int w);
    tick++;
    m_last[s][w] = tick;
  endfunction

  // Walk down the way-index bits: at each level evict from the half not holding the
  // most recently used way of the current group; an untouched group goes to bit 0.
  function automatic int model_victim(input int s);
    int pre;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    pre = 0;
    for (int l = 0; l < WAY_LOG; l++) begin
      int mask;
      int best;
      longint unsigned best_t;
      mask = (1 << l) - 1;
      best = -1;
      best_t = 0;
      for (int w = 0; w < WAYS; w++)
        if ((w & mask) == pre && m_last[s][w] > best_t) begin
          best = w;
          best_t = m_last[s][w];
        end
      if (best >= 0 && ((best >> l) & 1) == 0) pre = pre | (1 << l);
    end
    return pre;
  endfunction

  // ---------------- driver ----------------
  task automatic refill(input logic [63:0] base, input int s, input int lat);
    int way;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("b_rd_held", {63'd0, b_rd}, 64'd1);
      chk("b_addr", b_addr, base);
      if (c == lat) begin
        b_dv = 1'b1;
        b_data_in = mem_line(base);
      end
      #1;
      chk("refill_ready", {63'd0, ready}, 64'd0);
      @(posedge clk);
    end
    way = model_victim(s);
    m_valid[s][way] = 1'b1;
    m_line[s][way]  = base / LINE_BYTES;
    model_touch(s, way);
  endtask

  task automatic do_access(input logic [63:0] a, input logic [2:0] l, input bit st,
                           input logic [63:0] d, input int rd_lat, input int wa_lat);
    int sz, s, way, lat;
    bit mis, hit;
    logic [63:0] base;
    @(negedge clk);
    addr = a; len = l; wr = st; data_in = d;
    rd = st ? 1'($urandom_range(0, 1)) : 1'b1;
    sz = size_of(l);
    mis = (l == 3'd7) || (a % 64'(sz) != 0);
    base = a & ~64'(LINE_BYTES - 1);
    s = int'((a / LINE_BYTES) % SETS);
    #1;
    if (mis) begin
      chk("misalign_flag", {63'd0, misalign}, 64'd1);
      chk("misalign_ready", {63'd0, ready}, 64'd1);
      chk("misalign_b_rd", {63'd0, b_rd}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("misalign_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("misalign_bus", {62'd0, b_rd, b_wr}, 64'd0);
    end else begin
      chk("misalign_clear", {63'd0, misalign}, 64'd0);
      hit = model_lookup(a, way);
      lat = (rd_lat > 0) ? rd_lat : int'($urandom_range(1, 4));
      if (!st) begin
        if (hit) begin
          chk("hit_ready", {63'd0, ready}, 64'd1);
          chk("hit_data", data_out, load_value(a, l));
          model_touch(s, way);
          @(posedge clk);
        end else begin
          chk("miss_ready", {63'd0, ready}, 64'd0);
          @(posedge clk);
          refill(base, s, lat);
          @(negedge clk);
          b_dv = 1'b0;
          #1;
          chk("fill_b_rd_drop", {63'd0, b_rd}, 64'd0);
          chk("fill_ready", {63'd0, ready}, 64'd1);
          chk("fill_data", data_out, load_value(a, l));
          @(posedge clk);
        end
      end else begin
        chk("store_ready_idle", {63'd0, ready}, 64'd0);
        @(posedge clk);
        if (hit) model_touch(s, way);
        else refill(base, s, lat);
        for (int i = 0; i < sz; i++) mem[a + 64'(i)] = d[i*8 +: 8];
        lat = (wa_lat > 0) ? wa_lat : int'($urandom_range(1, 3));
        for (int c = 1; c <= lat; c++) begin
          @(negedge clk);
          b_dv = 1'b0;
          chk("b_wr_held", {63'd0, b_wr}, 64'd1);
          chk_line("b_data_out", b_data_out, mem_line(base));
          if (c == lat) b_wa = 1'b1;
          #1;
          chk("write_ready", {63'd0, ready}, (c == lat) ? 64'd1 : 64'd0);
          @(posedge clk);
        end
        @(negedge clk);
        b_wa = 1'b0;
        chk("b_wr_drop", {63'd0, b_wr}, 64'd0);
      end
    end
    if (!mis && !st) @(negedge clk);
    rd = 1'b0; wr = 1'b0; b_dv = 1'b0; b_wa = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] a, off;
    logic [2:0]  l;
    int          sz;
    model_reset();
    mem[64'h1040] = 8'h80;

    // Reset state, with a load presented against an empty cache.
    addr = 64'h1000; len = LEN_D; rd = 1'b1;
    #12;
    chk("rst_b_rd", {63'd0, b_rd}, 64'd0);
    chk("rst_b_wr", {63'd0, b_wr}, 64'd0);
    chk_line("rst_b_data_out", b_data_out, '0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    rd = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;

    // Cold load, signed/unsigned bytes, store hit and lwu read-back.
    do_access(64'h1000, LEN_D, 1'b0, 64'd0, 3, 0);
    do_access(64'h1040, LEN_B, 1'b0, 64'd0, 0, 0);
    do_access(64'h1040, LEN_BU, 1'b0, 64'd0, 0, 0);
    do_access(64'h1004, LEN_W, 1'b1, 64'h0000_0000_DEAD_BEEF, 0, 2);
    do_access(64'h1004, LEN_WU, 1'b0, 64'd0, 0, 0);
    do_access(64'h1006, LEN_H, 1'b0, 64'd0, 0, 0);

    // Misaligned doubleword load and reserved length.
    do_access(64'h1003, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h1008, LEN_RSV, 1'b1, 64'd5, 0, 0);

    // Replacement in set 0 starting from an empty cache.
    @(negedge clk); clr_n = 1'b0; model_reset();
    @(negedge clk); clr_n = 1'b1;
    do_access(64'h0000, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0200, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0400, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0600, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0000, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0800, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0200, LEN_D, 1'b0, 64'd0, 0, 0);
    do_access(64'h0000, LEN_D, 1'b0, 64'd0, 0, 0);

    // Store miss: refill merges the store, then one bus write.
    do_access(64'h2010, LEN_H, 1'b1, 64'h1234, 2, 1);
    do_access(64'h2010, LEN_HU, 1'b0, 64'd0, 0, 0);

    // Reset while a refill is outstanding.
    @(negedge clk);
    addr = 64'h3000; len = LEN_D; rd = 1'b1; wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_b_rd", {63'd0, b_rd}, 64'd1);
    clr_n = 1'b0;
    #1;
    chk("async_rst_b_rd", {63'd0, b_rd}, 64'd0);
    chk("async_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    model_reset();
    rd = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    do_access(64'h3000, LEN_D, 1'b0, 64'd0, 0, 0);

    // Random traffic over a small tag pool so sets overflow.
    for (int i = 0; i < 6; i++) tags[i] = (64'(i) << 8) | 64'($urandom_range(0, 255));
    for (int n = 0; n < 250; n++) begin
      l = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) l = LEN_RSV;
      sz = size_of(l);
      off = 64'($urandom_range(0, LINE_BYTES - 1));
      if ($urandom_range(0, 9) != 0) off = off & ~64'(sz - 1);
      a = (tags[$urandom_range(0, 5)] << 9) | (64'($urandom_range(0, SETS - 1)) << 7) | off;
      do_access(a, l, ($urandom_range(0, 2) == 0), {$urandom, $urandom}, 0, 0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
